// File: rtl/alarm_timer_pkg.sv
// Shared definitions for the anti-theft timing resource: interval codes,
// default delay values and timer state encodings.
package alarm_timer_pkg;

   localparam logic [1:0] INT_ARM = 2'b00;
   localparam logic [1:0] INT_DRV = 2'b01;
   localparam logic [1:0] INT_PAS = 2'b10;
   localparam logic [1:0] INT_ALM = 2'b11;

   localparam int DEF_T_ARM = 6;
   localparam int DEF_T_DRV = 8;
   localparam int DEF_T_PAS = 15;
   localparam int DEF_T_ALM = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } timer_state_e;

endpackage

// File: rtl/one_hz_divider.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// a synchronous clear restarts the period from zero.
module one_hz_divider #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/alarm_timer_ctrl.sv
// Timing resource for the anti-theft FSM: programmable delay parameters,
// a single countdown timer with one-cycle expired pulse, and the 1 Hz tick.
module alarm_timer_ctrl
   import alarm_timer_pkg::*;
#(
   parameter int TICK_DIV  = 100_000_000,
   parameter int VAL_W     = 4,
   parameter int T_ARM_DEF = DEF_T_ARM,
   parameter int T_DRV_DEF = DEF_T_DRV,
   parameter int T_PAS_DEF = DEF_T_PAS,
   parameter int T_ALM_DEF = DEF_T_ALM
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             reprogram,
   input  logic [1:0]       time_param_sel,
   input  logic [VAL_W-1:0] time_value,
   input  logic [1:0]       interval,
   input  logic             start_timer,
   output logic             one_hz_enable,
   output logic             expired,
   output logic             busy,
   output logic [VAL_W-1:0] count,
   output logic             reprog_ack
);

   timer_state_e     state;
   logic [VAL_W-1:0] param_q [4];
   logic             reprog_q;
   logic             reprog_edge;
   logic             start_acc;

   assign reprog_edge = reprogram & ~reprog_q;
   // A reprogram edge always wins over a simultaneous start request.
   assign start_acc   = start_timer & ~reprog_edge;

   one_hz_divider #(.TICK_DIV(TICK_DIV)) u_div (
      .clock (clock),
      .reset (reset),
      .clear (start_acc),
      .tick  (one_hz_enable)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         param_q[INT_ARM] <= VAL_W'(T_ARM_DEF);
         param_q[INT_DRV] <= VAL_W'(T_DRV_DEF);
         param_q[INT_PAS] <= VAL_W'(T_PAS_DEF);
         param_q[INT_ALM] <= VAL_W'(T_ALM_DEF);
         reprog_q   <= 1'b0;
         reprog_ack <= 1'b0;
         state      <= ST_IDLE;
         count      <= '0;
      end else begin
         reprog_q   <= reprogram;
         reprog_ack <= reprog_edge;
         if (reprog_edge) begin
            // Zero seconds is stored as one so a countdown never underflows.
            param_q[time_param_sel] <= (time_value == '0) ? VAL_W'(1) : time_value;
            state <= ST_IDLE;
            count <= '0;
         end else if (start_acc) begin
            count <= param_q[interval];
            state <= ST_RUN;
         end else begin
            case (state)
               ST_RUN: begin
                  if (one_hz_enable) begin
                     if (count == VAL_W'(1)) begin
                        count <= '0;
                        state <= ST_DONE;
                     end else begin
                        count <= count - VAL_W'(1);
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy    = (state == ST_RUN);
   assign expired = (state == ST_DONE);

endmodule

// File: tb/tb_alarm_timer_ctrl.sv
// Randomized and directed bench for alarm_timer_ctrl against a deadline-based
// reference model of the countdown, divider phase and parameter store.
module tb_alarm_timer_ctrl;
   import alarm_timer_pkg::*;

   localparam int TD = 4;
   localparam int VW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          reprogram = 1'b0;
   logic [1:0]    time_param_sel = 2'b00;
   logic [VW-1:0] time_value = '0;
   logic [1:0]    interval = 2'b00;
   logic          start_timer = 1'b0;
   logic          one_hz_enable;
   logic          expired;
   logic          busy;
   logic [VW-1:0] count;
   logic          reprog_ack;

   alarm_timer_ctrl #(.TICK_DIV(TD), .VAL_W(VW)) dut (
      .clock          (clock),
      .reset          (reset),
      .reprogram      (reprogram),
      .time_param_sel (time_param_sel),
      .time_value     (time_value),
      .interval       (interval),
      .start_timer    (start_timer),
      .one_hz_enable  (one_hz_enable),
      .expired        (expired),
      .busy           (busy),
      .count          (count),
      .reprog_ack     (reprog_ack)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // reference model: absolute-time view of the timer
   int prm [4];
   int deadline;
   int load_cyc;
   int load_val;
   int div_base;
   bit prev_rp;
   bit ack_e;
   int exp_seen [$];

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      prm[0] = 6; prm[1] = 8; prm[2] = 15; prm[3] = 10;
      deadline = -1;
      prev_rp  = 1'b0;
      ack_e    = 1'b0;
   endtask

   task automatic compare_outputs();
      int busy_e, exp_e, cnt_e, tick_e;
      busy_e = (deadline >= 0 && cyc < deadline) ? 1 : 0;
      exp_e  = (deadline >= 0 && cyc == deadline) ? 1 : 0;
      cnt_e  = busy_e ? load_val - (cyc - load_cyc - 1) / TD : 0;
      tick_e = (cyc >= div_base && ((cyc - div_base) % TD) == TD - 1) ? 1 : 0;
      check_eq("busy", int'(busy), busy_e);
      check_eq("expired", int'(expired), exp_e);
      check_eq("count", int'(count), cnt_e);
      check_eq("one_hz", int'(one_hz_enable), tick_e);
      check_eq("reprog_ack", int'(reprog_ack), int'(ack_e));
      if (expired) exp_seen.push_back(cyc);
   endtask

   // One clock cycle: check at the falling edge, then drive and advance the model.
   task automatic step(input bit rp, input logic [1:0] sel, input logic [VW-1:0] val,
                       input bit st, input logic [1:0] iv, output int c);
      bit edge_d;
      @(negedge clock);
      c = cyc;
      compare_outputs();
      reprogram = rp; time_param_sel = sel; time_value = val;
      start_timer = st; interval = iv;
      edge_d  = rp && !prev_rp;
      prev_rp = rp;
      ack_e   = edge_d;
      if (edge_d) begin
         prm[sel] = (val == 0) ? 1 : int'(val);
         deadline = -1;
      end else if (st) begin
         load_val = prm[iv];
         load_cyc = c;
         deadline = c + load_val * TD + 1;
         div_base = c + 1;
      end
   endtask

   task automatic idle(input int n);
      int c;
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, 1'b0, 2'b00, c);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_busy"}, int'(busy), 0);
      check_eq({tag, "_expired"}, int'(expired), 0);
      check_eq({tag, "_count"}, int'(count), 0);
      check_eq({tag, "_ack"}, int'(reprog_ack), 0);
      check_eq({tag, "_tick"}, int'(one_hz_enable), 0);
   endtask

   task automatic release_reset();
      @(negedge clock);
      reprogram = 1'b0; start_timer = 1'b0;
      reset = 1'b1;
      model_reset();
      div_base = cyc;
   endtask

   int defs [4] = '{6, 8, 15, 10};
   int n, c;

   initial begin
      model_reset();
      div_base = 0;
      repeat (3) @(posedge clock);
      #1 check_zero_outputs("rst");
      release_reset();

      // defaults readable through starts
      idle(3);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 2'b00, '0, 1'b1, 2'(i), n);
         @(posedge clock); #1 check_eq("default_param", int'(count), defs[i]);
      end
      idle(45);

      // driver delay latency
      exp_seen.delete();
      step(1'b0, 2'b00, '0, 1'b1, INT_DRV, n);
      idle(40);
      check_eq("drv_exp_count", exp_seen.size(), 1);
      if (exp_seen.size() > 0) check_eq("drv_exp_cycle", exp_seen[0], n + 33);

      // reprogram alarm to 3, then to 0 (stored as 1)
      step(1'b1, INT_ALM, 4'd3, 1'b0, 2'b00, c);
      @(posedge clock); #1 check_eq("ack_pulse", int'(reprog_ack), 1);
      step(1'b1, INT_ALM, 4'd3, 1'b0, 2'b00, c);
      idle(2);
      exp_seen.delete();
      step(1'b0, 2'b00, '0, 1'b1, INT_ALM, n);
      idle(16);
      check_eq("alm3_exp_count", exp_seen.size(), 1);
      if (exp_seen.size() > 0) check_eq("alm3_exp_cycle", exp_seen[0], n + 13);
      step(1'b1, INT_ALM, 4'd0, 1'b0, 2'b00, c);
      idle(2);
      exp_seen.delete();
      step(1'b0, 2'b00, '0, 1'b1, INT_ALM, n);
      idle(8);
      check_eq("alm0_exp_count", exp_seen.size(), 1);
      if (exp_seen.size() > 0) check_eq("alm0_exp_cycle", exp_seen[0], n + 5);

      // restart mid-run
      exp_seen.delete();
      step(1'b0, 2'b00, '0, 1'b1, INT_ARM, n);
      idle(9);
      step(1'b0, 2'b00, '0, 1'b1, INT_PAS, c);
      idle(65);
      check_eq("restart_exp_count", exp_seen.size(), 1);
      if (exp_seen.size() > 0) check_eq("restart_exp_cycle", exp_seen[0], n + 71);

      // reprogram aborts a run; reprogram beats a coincident start
      exp_seen.delete();
      step(1'b0, 2'b00, '0, 1'b1, INT_DRV, n);
      idle(10);
      step(1'b1, INT_ARM, 4'd7, 1'b0, 2'b00, c);
      @(posedge clock); #1 check_eq("abort_busy", int'(busy), 0);
      check_eq("abort_count", int'(count), 0);
      idle(40);
      check_eq("abort_no_exp", exp_seen.size(), 0);
      step(1'b1, INT_PAS, 4'd9, 1'b1, INT_DRV, c);
      @(posedge clock); #1 check_eq("coincide_busy", int'(busy), 0);
      idle(40);
      check_eq("coincide_no_exp", exp_seen.size(), 0);

      // asynchronous reset mid-run
      step(1'b0, 2'b00, '0, 1'b1, INT_PAS, n);
      idle(10);
      @(posedge clock); #2 reset = 1'b0;
      #1 check_zero_outputs("async_rst");
      @(posedge clock);
      release_reset();
      step(1'b0, 2'b00, '0, 1'b1, INT_ARM, n);
      @(posedge clock); #1 check_eq("rst_arm_default", int'(count), 6);
      step(1'b0, 2'b00, '0, 1'b1, INT_ALM, n);
      @(posedge clock); #1 check_eq("rst_alm_default", int'(count), 10);
      step(1'b0, 2'b00, '0, 1'b1, INT_PAS, n);
      @(posedge clock); #1 check_eq("rst_pas_default", int'(count), 9 + 6);

      // randomized traffic
      begin
         bit rp = 1'b0;
         for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) rp = ~rp;
            step(rp, 2'($urandom_range(0, 3)), VW'($urandom_range(0, 15)),
                 ($urandom_range(0, 14) == 0), 2'($urandom_range(0, 3)), c);
         end
      end
      idle(70);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
